// File: rtl/spike_readout.sv
`default_nettype none
// ============================================================================
//  Module      : spike_readout
//  Description : Counts output-layer spikes per class over an inference frame,
//                snapshots the counts when the frame closes, finds the winning
//                class with a sequential scan and streams a result packet
//                ({overrun,3'b0,idx}, count[0..N_OUT-1]) over a byte
//                valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_readout #(
   parameter int N_OUT   = 10,
   parameter int COUNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_OUT-1:0] spikes,
   input  logic             step_valid,
   input  logic             frame_end,
   input  logic             tx_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   output logic             busy,
   output logic             overrun
);

   localparam int                 c_IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(N_OUT - 1);
   localparam logic [COUNT_W-1:0] c_SAT   = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;

   logic [COUNT_W-1:0] r_cnt  [N_OUT];
   logic [COUNT_W-1:0] w_eff  [N_OUT];
   logic [COUNT_W-1:0] r_snap [N_OUT];
   logic [COUNT_W-1:0] r_best;
   logic [c_IDX_W-1:0] r_idx;
   logic [c_IDX_W-1:0] r_k;
   logic [c_IDX_W-1:0] r_pos;
   logic [c_IDX_W-1:0] w_pos_nx;
   logic               r_hdr;
   logic               r_ov;
   logic               r_tx_valid;
   logic [7:0]         r_tx_data;
   logic               w_ov_set;
   logic               w_ov_clr;
   logic               w_xfer;
   logic [3:0]         w_idx4;

   // A frame closing while the previous result is still in flight is lost.
   assign w_ov_set = frame_end && (r_state != S_IDLE);
   assign w_xfer   = r_tx_valid && tx_ready;
   // Only a header that actually reported the overrun clears it.
   assign w_ov_clr = w_xfer && r_hdr && r_tx_data[7];
   assign w_pos_nx = r_pos + 1'b1;
   assign w_idx4   = 4'(r_idx);

   assign tx_data  = r_tx_data;
   assign tx_valid = r_tx_valid;
   assign overrun  = r_ov;

   // Saturating count including any spike arriving in the current step.
   always_comb begin
      for (int i = 0; i < N_OUT; i++) begin
         w_eff[i] = r_cnt[i];
         if (step_valid && spikes[i] && (r_cnt[i] != c_SAT)) begin
            w_eff[i] = r_cnt[i] + 1'b1;
         end
      end
   end

   // Per-class spike counters; cleared at every frame boundary in any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_OUT; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (frame_end) begin
         for (int i = 0; i < N_OUT; i++) begin
            r_cnt[i] <= '0;
         end
      end else if (step_valid) begin
         for (int i = 0; i < N_OUT; i++) begin
            r_cnt[i] <= w_eff[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic and busy flag.
   always_comb begin
      w_state_nx = r_state;
      busy       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frame_end) begin
               w_state_nx = S_SCAN;
            end
         end
         S_SCAN: begin
            busy = 1'b1;
            if (r_k == c_LAST) begin
               w_state_nx = S_SEND;
            end
         end
         S_SEND: begin
            busy = 1'b1;
            if (w_xfer && !r_hdr && (r_pos == c_LAST)) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Snapshot capture, argmax scan and packet byte sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_OUT; i++) begin
            r_snap[i] <= '0;
         end
         r_best     <= '0;
         r_idx      <= '0;
         r_k        <= '0;
         r_pos      <= '0;
         r_hdr      <= 1'b0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (frame_end) begin
                  for (int i = 0; i < N_OUT; i++) begin
                     r_snap[i] <= w_eff[i];
                  end
                  r_best <= w_eff[0];
                  r_idx  <= '0;
                  r_k    <= '0;
               end
            end
            S_SCAN: begin
               // Strict compare keeps the lowest index on ties.
               if (r_snap[r_k] > r_best) begin
                  r_best <= r_snap[r_k];
                  r_idx  <= r_k;
               end
               r_k <= r_k + 1'b1;
            end
            S_SEND: begin
               if (!r_tx_valid) begin
                  r_tx_valid <= 1'b1;
                  r_hdr      <= 1'b1;
                  r_tx_data  <= {r_ov | w_ov_set, 3'b000, w_idx4};
               end else if (w_xfer) begin
                  if (r_hdr) begin
                     r_hdr     <= 1'b0;
                     r_pos     <= '0;
                     r_tx_data <= 8'(r_snap[0]);
                  end else if (r_pos == c_LAST) begin
                     r_tx_valid <= 1'b0;
                     r_tx_data  <= '0;
                  end else begin
                     r_pos     <= w_pos_nx;
                     r_tx_data <= 8'(r_snap[w_pos_nx]);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Sticky overrun; a new overrun wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ov <= 1'b0;
      end else if (w_ov_set) begin
         r_ov <= 1'b1;
      end else if (w_ov_clr) begin
         r_ov <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spike_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_readout
//  Description : Self-checking bench for spike_readout: packet-level reference
//                model compared every cycle, plus literal packet expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_readout;

   localparam int N = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] spikes;
   logic         step_valid;
   logic         frame_end;
   logic         tx_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         busy;
   logic         overrun;

   always #5 clk = ~clk;

   spike_readout #(.N_OUT(N), .COUNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spikes     (spikes),
      .step_valid (step_valid),
      .frame_end  (frame_end),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (packet level) ----------------
   int         m_cnt [N];
   logic [7:0] q[$];
   bit         m_busy = 1'b0;
   bit         m_ov   = 1'b0;
   int         m_tv   = 0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   bit         prev_valid = 1'b0;
   int         last_rise  = -1;
   logic [7:0] rx_log[$];

   always @(negedge clk) begin
      bit         exp_valid, xfer, ov_set, ov_clr, busy_now;
      int         eff [N];
      int         best, bi;
      logic [7:0] b;
      if (!rst_n) begin
         chk("rst_tx_valid", tx_valid, 0);
         chk("rst_tx_data", tx_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_overrun", overrun, 0);
         foreach (m_cnt[i]) m_cnt[i] = 0;
         q.delete();
         m_busy     = 1'b0;
         m_ov       = 1'b0;
         prev_stall = 1'b0;
         prev_valid = 1'b0;
      end else begin
         busy_now  = m_busy;
         exp_valid = m_busy && (cyc >= m_tv);
         if (m_busy && (cyc == m_tv)) begin
            b    = q[0];
            b[7] = m_ov;
            q[0] = b;
         end
         chk("busy", busy, int'(m_busy));
         chk("overrun", overrun, int'(m_ov));
         chk("tx_valid", tx_valid, int'(exp_valid));
         if (exp_valid) chk("tx_data", tx_data, q[0]);
         if (prev_stall) chk("stall_hold", tx_data, prev_data);
         if (tx_valid && !prev_valid) last_rise = cyc;
         if (tx_valid && tx_ready) rx_log.push_back(tx_data);
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_valid = tx_valid;

         xfer   = exp_valid && tx_ready;
         ov_set = frame_end && busy_now;
         ov_clr = 1'b0;
         for (int i = 0; i < N; i++) begin
            eff[i] = m_cnt[i] + ((step_valid && spikes[i]) ? 1 : 0);
            if (eff[i] > 255) eff[i] = 255;
         end
         if (xfer) begin
            b = q[0];
            if ((q.size() == N + 1) && b[7]) ov_clr = 1'b1;
            void'(q.pop_front());
            if (q.size() == 0) m_busy = 1'b0;
         end
         if (frame_end) begin
            if (!busy_now) begin
               best = eff[0];
               bi   = 0;
               for (int i = 1; i < N; i++) begin
                  if (eff[i] > best) begin
                     best = eff[i];
                     bi   = i;
                  end
               end
               q.delete();
               q.push_back(8'(bi));
               for (int i = 0; i < N; i++) q.push_back(8'(eff[i]));
               m_busy = 1'b1;
               m_tv   = cyc + N + 2;
            end
            foreach (m_cnt[i]) m_cnt[i] = 0;
         end else if (step_valid) begin
            foreach (m_cnt[i]) m_cnt[i] = eff[i];
         end
         if (ov_set) m_ov = 1'b1;
         else if (ov_clr) m_ov = 1'b0;
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   int rdy_mode = 0;
   int pc       = 0;

   task automatic tick(input bit sv, input logic [N-1:0] sp, input bit fe);
      step_valid = sv;
      spikes     = sp;
      frame_end  = fe;
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = (pc % 3 == 0);
         2:       tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
      pc++;
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((busy || tx_valid) && (n < budget)) begin
         tick(1'b0, '0, 1'b0);
         n++;
      end
      chk("drain_timeout", int'(busy || tx_valid), 0);
   endtask

   // Compare 11 logged bytes from base against a literal packet.
   task automatic chk_pkt(input string name, input int base, input int p0, input int p1,
                          input int p2, input int p3, input int p4, input int p5,
                          input int p6, input int p7, input int p8, input int p9,
                          input int p10);
      int e [11];
      e = '{p0, p1, p2, p3, p4, p5, p6, p7, p8, p9, p10};
      chk({name, "_len"}, rx_log.size() - base, 11);
      if (rx_log.size() - base == 11) begin
         for (int i = 0; i < 11; i++) chk($sformatf("%s_b%0d", name, i), rx_log[base + i], e[i]);
      end
   endtask

   int           base;
   int           t0;
   int           n;
   logic [N-1:0] rs;

   initial begin
      rst_n      = 1'b0;
      step_valid = 1'b0;
      spikes     = '0;
      frame_end  = 1'b0;
      tx_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_tx_valid", tx_valid, 0);
      chk("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (2) tick(1'b0, '0, 1'b0);

      // Basic frame
      rdy_mode = 0;
      base = rx_log.size();
      repeat (5) tick(1'b1, 10'b0000001000, 1'b0);
      repeat (2) tick(1'b1, 10'b0000000001, 1'b0);
      t0 = cyc;
      tick(1'b0, '0, 1'b1);
      drain(100);
      chk_pkt("basic", base, 8'h03, 2, 0, 0, 5, 0, 0, 0, 0, 0, 0);
      chk("basic_latency", last_rise - t0, 12);
      chk("basic_busy_end", busy, 0);

      // Tie plus same-cycle spike
      base = rx_log.size();
      repeat (3) tick(1'b1, 10'b0010000100, 1'b0);
      tick(1'b1, 10'b0000000100, 1'b0);
      tick(1'b1, 10'b0010000000, 1'b1);
      drain(100);
      chk_pkt("tie", base, 8'h02, 0, 0, 4, 0, 0, 0, 0, 4, 0, 0);

      // Saturation
      base = rx_log.size();
      repeat (300) tick(1'b1, '1, 1'b0);
      tick(1'b0, '0, 1'b1);
      drain(100);
      chk_pkt("sat", base, 8'h00, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255);

      // Backpressure 1,0,0,...
      rdy_mode = 1;
      base = rx_log.size();
      repeat (6) tick(1'b1, 10'b1000000000, 1'b0);
      repeat (2) tick(1'b1, 10'b0000010000, 1'b0);
      tick(1'b0, '0, 1'b1);
      drain(200);
      chk_pkt("bp", base, 8'h09, 0, 0, 0, 0, 2, 0, 0, 0, 0, 6);

      // Overrun during a stalled SEND
      rdy_mode = 3;
      base = rx_log.size();
      repeat (3) tick(1'b1, 10'b0000000010, 1'b0);
      tick(1'b0, '0, 1'b1);
      n = 0;
      while (!tx_valid && (n < 50)) begin
         tick(1'b0, '0, 1'b0);
         n++;
      end
      chk("ovr_wait_valid", tx_valid, 1);
      tick(1'b0, '0, 1'b1);
      chk("ovr_set", overrun, 1);
      repeat (3) tick(1'b0, '0, 1'b0);
      rdy_mode = 0;
      drain(100);
      chk_pkt("ovr_cur", base, 8'h01, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("ovr_sticky", overrun, 1);
      base = rx_log.size();
      repeat (2) tick(1'b1, 10'b0001000000, 1'b0);
      tick(1'b0, '0, 1'b1);
      drain(100);
      chk_pkt("ovr_next", base, 8'h86, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
      chk("ovr_cleared", overrun, 0);

      // Reset in the middle of SEND
      base = rx_log.size();
      repeat (3) tick(1'b1, 10'b0000100000, 1'b0);
      tick(1'b0, '0, 1'b1);
      n = 0;
      while ((rx_log.size() - base < 3) && (n < 50)) begin
         tick(1'b1, 10'b0000000001, 1'b0);
         n++;
      end
      chk("rstmid_three_bytes", rx_log.size() - base, 3);
      rst_n = 1'b0;
      #1;
      chk("rstmid_tx_valid", tx_valid, 0);
      chk("rstmid_busy", busy, 0);
      #1;
      repeat (2) tick(1'b0, '0, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, '0, 1'b0);
      base = rx_log.size();
      repeat (2) tick(1'b1, 10'b0100000000, 1'b0);
      tick(1'b0, '0, 1'b1);
      drain(100);
      chk_pkt("rstmid_clean", base, 8'h08, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);

      // Randomized traffic against the model
      rdy_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         rs = N'($urandom());
         tick(($urandom_range(0, 3) != 0), rs, ($urandom_range(0, 39) == 0));
      end
      rdy_mode = 0;
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual=timeout required=finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/spike_readout.md
Name: spike_readout

Overview:
- Output-side counterpart to the neuron network's byte/strobe input-loading interface.
- Counts output-layer spikes per class over an inference window (a "frame") and snapshots the counts when the frame closes.
- Finds the winning class (argmax) with a sequential scan, then streams a result packet out over an 8-bit valid/ready byte interface.
- Sits between the output layer of the network and the tile's dedicated output pins.

Parameters:
- N_OUT, 10, number of output-layer neurons/classes (2..16).
- COUNT_W, 8, spike counter width per class; fixed at 8 so each count fits in one byte.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- spikes  input  N_OUT  output-layer spike vector, sampled only when step_valid=1.
- step_valid  input  1  one network timestep completed this cycle.
- frame_end  input  1  close the current inference window this cycle.
- tx_ready  input  1  downstream accepts a byte this cycle.
- tx_data  output  8  packet byte.
- tx_valid  output  1  tx_data is valid.
- busy  output  1  argmax scan or packet transmission in progress.
- overrun  output  1  sticky: a frame closed while busy.

Behaviour:
- Reset (async, rst_n=0):
  - All counters, snapshot registers, state and outputs cleared.
  - tx_valid=0, tx_data=0, busy=0, overrun=0.
  - FSM enters IDLE.
- Accumulation runs in every state, independent of the FSM:
  - On step_valid=1, cnt[i] <= cnt[i] + spikes[i].
  - Saturates at 255; no wrap.
- On frame_end=1:
  - Effective count eff[i] = sat(cnt[i] + (step_valid & spikes[i])). A spike arriving in the same cycle belongs to the closing frame.
  - All cnt[i] <= 0 next cycle, regardless of FSM state.
  - If FSM is IDLE: snap[i] <= eff[i]; go to SCAN.
  - If FSM is not IDLE: the frame is discarded, overrun <= 1, and the snapshot is untouched.
- FSM states:
  - IDLE: busy=0. Waits for frame_end.
  - SCAN: busy=1. Takes N_OUT cycles, index k = 0..N_OUT-1.
    - Starts from best=snap[0], idx=0.
    - At each k>0, update only if snap[k] > best (strict), so ties resolve to the lowest index.
    - After the last index, go to SEND.
  - SEND: busy=1. Emits the packet of N_OUT+1 bytes:
    - byte0 = {overrun, 3'b000, idx[3:0]}.
    - bytes 1..N_OUT = snap[0]..snap[N_OUT-1].
    - After the last byte is accepted, go to IDLE.
- Byte handshake:
  - tx_valid is asserted the cycle after entering SEND.
  - A byte transfers when tx_valid && tx_ready.
  - tx_data and tx_valid are registered and held stable until accepted. tx_valid must not drop without a transfer.
  - The next byte is presented the cycle after a transfer. Back-to-back transfers give 1 byte/cycle.
  - tx_valid deasserts the cycle after the last byte is accepted.
- overrun:
  - Sticky. Reported in byte0 of the next packet.
  - Cleared when that byte0 transfers, unless a new overrun occurs in the same cycle, in which case it stays 1.
- Latency: frame_end at cycle T gives SCAN during T+1..T+N_OUT; byte0 is valid at T+N_OUT+2.
- Mid-operation reset returns everything to reset values immediately. No partial packet resumes.
- spikes is ignored when step_valid=0. tx_ready is ignored when tx_valid=0.

Test Plan:
- Basic frame:
  - Stimulus: reset; 5 steps with spikes=10'b0000001000 (class 3), 2 steps with spikes=10'b0000000001; frame_end; tx_ready=1.
  - Required: packet 0x03, 2,0,0,5,0,0,0,0,0,0. byte0 valid exactly 12 cycles after frame_end (T+N_OUT+2). busy=0 after the last byte.
- Tie and same-cycle spike:
  - Stimulus: classes 2 and 7 each spike 4 times; the last class-7 spike coincides with frame_end.
  - Required: counts 4 and 4; byte0=0x02 (lowest index wins).
- Saturation:
  - Stimulus: 300 steps with spikes=all ones.
  - Required: every count byte = 0xFF; argmax = 0.
- Backpressure:
  - Stimulus: tx_ready toggles 1,0,0,1,... during SEND.
  - Required: tx_data and tx_valid stable while stalled; all 11 bytes delivered in order, none duplicated or skipped.
- Overrun:
  - Stimulus: second frame_end during SEND with tx_ready=0.
  - Required: overrun=1; the current packet completes unchanged; the next frame's byte0 has bit7=1; overrun=0 after that byte0 transfers.
- Reset mid-SEND:
  - Stimulus: drop rst_n after 3 bytes have transferred.
  - Required: tx_valid=0 and busy=0 immediately. A following clean frame yields a full, correct packet with zeroed prior counts.
